// File: rtl/rc5_pkg.sv
// Shared constants, size derivations and FSM encoding for the RC5-32 key schedule.
package rc5_pkg;

    localparam logic [31:0] PW = 32'hB7E15163;
    localparam logic [31:0] QW = 32'h9E3779B9;

    typedef enum logic [2:0] {
        StIdle,
        StClrL,
        StLoadL,
        StInitS,
        StMixS,
        StMixL,
        StZeroL,
        StDone
    } rc5_state_e;

    function automatic int unsigned rc5_u(input int unsigned w);
        return w / 8;
    endfunction

    function automatic int unsigned rc5_c(input int unsigned w, input int unsigned b);
        int unsigned u;
        int unsigned c;
        u = w / 8;
        c = (b + u - 1) / u;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int unsigned rc5_t(input int unsigned r);
        return 2 * (r + 1);
    endfunction

    function automatic int unsigned rc5_n(input int unsigned t, input int unsigned c);
        return 3 * ((t > c) ? t : c);
    endfunction

    // Address width with a floor of one bit so single-entry RAMs still get a port
    function automatic int unsigned rc5_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit left rotate by a 5-bit amount.
module rc5_rotl #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    input  logic [4:0]   amt,
    output logic [W-1:0] dout
);

    logic [2*W-1:0] dbl;

    // Shift a doubled copy so bits leaving the top reappear at the bottom
    always_comb begin
        dbl  = {din, din} << amt;
        dout = dbl[2*W-1:W];
    end

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5-32/R/B key expansion sequencer driving the K, L and S RAMs.
// Optional build macro RC5_KEY_ZEROIZE_EN adds a pass that wipes L before done.
module rc5_key_sched_ctrl
    import rc5_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned B = 16,
    parameter int unsigned R = 12,
    localparam int unsigned U   = rc5_u(W),
    localparam int unsigned C   = rc5_c(W, B),
    localparam int unsigned T   = rc5_t(R),
    localparam int unsigned N   = rc5_n(T, C),
    localparam int unsigned KAW = rc5_aw(B),
    localparam int unsigned LAW = rc5_aw(C),
    localparam int unsigned SAW = rc5_aw(T)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [KAW-1:0] key_addr,
    input  logic [7:0]     key_rd_data,
    output logic [LAW-1:0] l_addr,
    output logic           l_wr_en,
    output logic [W-1:0]   l_wr_data,
    input  logic [W-1:0]   l_rd_data,
    output logic [SAW-1:0] s_addr,
    output logic           s_wr_en,
    output logic [W-1:0]   s_wr_data,
    input  logic [W-1:0]   s_rd_data
);

    // One counter serves every phase, so it must reach the largest of N and B
    localparam int unsigned CNTW = rc5_aw((N > B) ? N : B);

    rc5_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SAW-1:0]  i_q, i_d;
    logic [LAW-1:0]  j_q, j_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sprev_q, sprev_d;
    logic [W-1:0]    a_sum, a_rot, ab_sum, b_sum, b_rot;
    logic [4:0]      b_amt;

    // Mixing datapath; in MIX_L a_q already holds the freshly written A'
    always_comb begin
        a_sum  = s_rd_data + a_q + b_q;
        ab_sum = a_q + b_q;
        b_sum  = l_rd_data + ab_sum;
        b_amt  = ab_sum[4:0];
    end

    rc5_rotl #(.W(W)) u_rotl_a (
        .din  (a_sum),
        .amt  (5'd3),
        .dout (a_rot)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .din  (b_sum),
        .amt  (b_amt),
        .dout (b_rot)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sprev_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sprev_q <= sprev_d;
        end
    end

    // Next-state sequencing and RAM port drive
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        a_d       = a_q;
        b_d       = b_q;
        sprev_d   = sprev_q;
        busy      = 1'b0;
        done      = 1'b0;
        key_addr  = '0;
        l_addr    = '0;
        l_wr_en   = 1'b0;
        l_wr_data = '0;
        s_addr    = '0;
        s_wr_en   = 1'b0;
        s_wr_data = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClrL;
                    cnt_d   = '0;
                end
            end
            StClrL: begin
                busy    = 1'b1;
                l_addr  = LAW'(cnt_q);
                l_wr_en = 1'b1;
                if (cnt_q == CNTW'(C - 1)) begin
                    state_d = StLoadL;
                    cnt_d   = CNTW'(B - 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoadL: begin
                busy      = 1'b1;
                key_addr  = KAW'(cnt_q);
                l_addr    = LAW'(cnt_q / CNTW'(U));
                l_wr_en   = 1'b1;
                l_wr_data = {l_rd_data[W-9:0], key_rd_data};
                if (cnt_q == '0) begin
                    state_d = StInitS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StInitS: begin
                busy      = 1'b1;
                s_addr    = SAW'(cnt_q);
                s_wr_en   = 1'b1;
                s_wr_data = (cnt_q == '0) ? PW : sprev_q + QW;
                sprev_d   = s_wr_data;
                if (cnt_q == CNTW'(T - 1)) begin
                    state_d = StMixS;
                    cnt_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMixS: begin
                busy      = 1'b1;
                s_addr    = i_q;
                s_wr_en   = 1'b1;
                s_wr_data = a_rot;
                a_d       = a_rot;
                state_d   = StMixL;
            end
            StMixL: begin
                busy      = 1'b1;
                l_addr    = j_q;
                l_wr_en   = 1'b1;
                l_wr_data = b_rot;
                b_d       = b_rot;
                i_d       = (i_q == SAW'(T - 1)) ? '0 : i_q + 1'b1;
                j_d       = (j_q == LAW'(C - 1)) ? '0 : j_q + 1'b1;
                if (cnt_q == CNTW'(N - 1)) begin
`ifdef RC5_KEY_ZEROIZE_EN
                    state_d = StZeroL;
                    cnt_d   = '0;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StMixS;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
`ifdef RC5_KEY_ZEROIZE_EN
            StZeroL: begin
                busy    = 1'b1;
                l_addr  = LAW'(cnt_q);
                l_wr_en = 1'b1;
                if (cnt_q == CNTW'(C - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Directed bench for rc5_key_sched_ctrl with default parameters (W=32, B=16, R=12).
module tb_rc5_key_sched_ctrl;

    localparam int C = 4;
    localparam int B = 16;
    localparam int T = 26;
    localparam int N = 78;
`ifdef RC5_KEY_ZEROIZE_EN
    localparam int LAT = C + B + T + 2 * N + C;
`else
    localparam int LAT = C + B + T + 2 * N;
`endif
    localparam logic [31:0] PW = 32'hB7E15163;
    localparam logic [31:0] QW = 32'h9E3779B9;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  key_addr;
    logic [7:0]  key_rd_data;
    logic [1:0]  l_addr;
    logic        l_wr_en;
    logic [31:0] l_wr_data;
    logic [31:0] l_rd_data;
    logic [4:0]  s_addr;
    logic        s_wr_en;
    logic [31:0] s_wr_data;
    logic [31:0] s_rd_data;

    logic [7:0]  k_mem [16];
    logic [31:0] l_mem [4];
    logic [31:0] s_mem [32];
    logic [31:0] l_snap [4];
    logic [31:0] s_snap [32];
    logic [31:0] exp_l [4];
    logic [31:0] exp_s [26];

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    rc5_key_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .key_addr    (key_addr),
        .key_rd_data (key_rd_data),
        .l_addr      (l_addr),
        .l_wr_en     (l_wr_en),
        .l_wr_data   (l_wr_data),
        .l_rd_data   (l_rd_data),
        .s_addr      (s_addr),
        .s_wr_en     (s_wr_en),
        .s_wr_data   (s_wr_data),
        .s_rd_data   (s_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: combinational read, write at the clock edge
    assign key_rd_data = k_mem[key_addr];
    assign l_rd_data   = l_mem[l_addr];
    assign s_rd_data   = s_mem[s_addr];

    always @(posedge clk) begin
        if (l_wr_en) l_mem[l_addr] <= l_wr_data;
        if (s_wr_en) s_mem[s_addr] <= s_wr_data;
    end

    // Strobe exclusivity, address range and idle-quiet monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (l_wr_en && s_wr_en) viol = viol + 1;
            if (s_wr_en && s_addr >= 5'd26) viol = viol + 1;
            if (!busy && (l_wr_en || s_wr_en)) viol = viol + 1;
            if (done && busy) viol = viol + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int m;
        m = n & 31;
        return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
    endfunction

    // Textbook RC5 key expansion over the current k_mem contents
    task automatic build_model();
        logic [31:0] a, b;
        logic [31:0] l [4];
        logic [31:0] s [26];
        int ii, jj;
        for (int x = 0; x < C; x++) l[x] = 32'd0;
        for (int x = B - 1; x >= 0; x--) l[x / 4] = (l[x / 4] << 8) + {24'd0, k_mem[x]};
        s[0] = PW;
        for (int x = 1; x < T; x++) s[x] = s[x - 1] + QW;
        a = 32'd0;
        b = 32'd0;
        ii = 0;
        jj = 0;
        for (int x = 0; x < N; x++) begin
            a = rotl(s[ii] + a + b, 3);
            s[ii] = a;
            b = rotl(l[jj] + a + b, int'(a + b));
            l[jj] = b;
            ii = (ii + 1) % T;
            jj = (jj + 1) % C;
        end
        for (int x = 0; x < C; x++) exp_l[x] = l[x];
        for (int x = 0; x < T; x++) exp_s[x] = s[x];
    endtask

    // One expansion: start handshake, optional ignored start pulse, optional abort by reset
    task automatic do_run(input int poke, input int abort_at, output int lat, output int ndone);
        int cyc;
        bit fin;
        lat   = -1;
        ndone = 0;
        fin   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        cyc = 0;
        while (!fin && cyc < 1000) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (poke > 0 && cyc == poke) start = 1'b1;
            if (poke > 0 && cyc == poke + 1) start = 1'b0;
            if (cyc == C + B) for (int x = 0; x < C; x++) l_snap[x] = l_mem[x];
            if (cyc == C + B + T) for (int x = 0; x < 32; x++) s_snap[x] = s_mem[x];
            if (done) begin
                ndone = ndone + 1;
                if (lat < 0) lat = cyc;
            end
            if (lat >= 0 && cyc == lat + 1) fin = 1'b1;
            if (abort_at > 0 && cyc == abort_at) begin
                rst = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_final(input string tag);
        for (int x = 0; x < T; x++) check($sformatf("%s_s%0d", tag, x), s_mem[x], exp_s[x]);
        for (int x = 0; x < C; x++) begin
`ifdef RC5_KEY_ZEROIZE_EN
            check($sformatf("%s_l%0d_zero", tag, x), l_mem[x], 32'd0);
`else
            check($sformatf("%s_l%0d", tag, x), l_mem[x], exp_l[x]);
`endif
        end
    endtask

    typedef struct {
        string       name;
        bit          is_s;
        int          idx;
        logic [31:0] exp;
    } snap_vec_t;

    snap_vec_t   vec [9];
    logic [127:0] kv;
    logic [31:0]  act;
    int           lat;
    int           nd;

    initial begin
        vec[0] = '{"packed_l0", 1'b0, 0, 32'h03020100};
        vec[1] = '{"packed_l1", 1'b0, 1, 32'h07060504};
        vec[2] = '{"packed_l2", 1'b0, 2, 32'h0B0A0908};
        vec[3] = '{"packed_l3", 1'b0, 3, 32'h0F0E0D0C};
        vec[4] = '{"init_s0", 1'b1, 0, 32'hB7E15163};
        vec[5] = '{"init_s1", 1'b1, 1, 32'h5618CB1C};
        vec[6] = '{"init_s2", 1'b1, 2, 32'hF45044D5};
        vec[7] = '{"init_s3", 1'b1, 3, 32'h9287BE8E};
        vec[8] = '{"init_s25", 1'b1, 25, PW + 32'd25 * QW};

        rst   = 1'b1;
        start = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_l_wr_en", 32'(l_wr_en), 32'd0);
        check("rst_s_wr_en", 32'(s_wr_en), 32'd0);
        check("rst_s_addr", 32'(s_addr), 32'd0);
        check("rst_l_wr_data", l_wr_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Run 1: K[i]=i, phase snapshots and full result
        for (int x = 0; x < B; x++) k_mem[x] = 8'(x);
        build_model();
        do_run(0, 0, lat, nd);
        check("run1_latency", lat, LAT);
        check("run1_done_count", nd, 32'd1);
        check("run1_busy_after", 32'(busy), 32'd0);
        for (int v = 0; v < 9; v++) begin
            act = vec[v].is_s ? s_snap[vec[v].idx] : l_snap[vec[v].idx];
            check(vec[v].name, act, vec[v].exp);
        end
        check_final("run1");

        // Run 2: reference key, reset at cycle 100 abandons the run
        kv = 128'hFFFEEEE58684FFF05FFE493853000434;
        for (int x = 0; x < B; x++) k_mem[x] = kv[8 * x +: 8];
        build_model();
        do_run(0, 100, lat, nd);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_strobes", {30'd0, l_wr_en, s_wr_en}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (done) nd = nd + 1;
        end
        rst = 1'b0;
        check("abort_no_done", nd, 32'd0);

        // Run 3: same key after abort, with a start pulse while busy
        do_run(50, 0, lat, nd);
        check("run3_latency", lat, LAT);
        check("run3_done_count", nd, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("run3_no_restart", 32'(busy), 32'd0);
        check_final("run3");

        check("protocol_violations", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
